// File: rtl/lfsr_pkg.sv
// Shared mode encodings for the lfsr_load_n register and its next-state logic.
package lfsr_pkg;

    typedef enum logic [1:0] {
        MODE_FIB  = 2'b00,
        MODE_GAL  = 2'b01,
        MODE_ROT  = 2'b10,
        MODE_HOLD = 2'b11
    } lfsr_mode_e;

    function automatic logic mode_can_lock(input lfsr_mode_e m);
        return (m == MODE_FIB) || (m == MODE_GAL);
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state for the shift register: Fibonacci, Galois, rotate or hold.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b110
) (
    input  logic [WIDTH-1:0] q_i,
    input  lfsr_mode_e       mode_i,
    output logic [WIDTH-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        unique case (mode_i)
            MODE_FIB:  q_next_o = {q_i[WIDTH-2:0], ^(q_i & TAPS)};
            MODE_GAL:  q_next_o = (q_i >> 1) ^ (q_i[0] ? TAPS : '0);
            MODE_ROT:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_HOLD: q_next_o = q_i;
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/lfsr_load_n.sv
// Loadable multi-mode LFSR with lock-up recovery, step counting and cycle-period measurement.
module lfsr_load_n
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b110,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             L,
    input  logic [WIDTH-1:0] r,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] step_cnt,
    output logic [WIDTH-1:0] period,
    output logic             wrap,
    output logic             lockup
);

    logic [WIDTH-1:0] q_q, anchor_q, cnt_q, period_q;
    logic             wrap_q, lockup_q;
    logic [WIDTH-1:0] q_d;
    lfsr_mode_e       mode_e;
    logic             step_act, is_lock;

    assign mode_e   = lfsr_mode_e'(mode);
    assign step_act = en && (mode_e != MODE_HOLD);
    assign is_lock  = mode_can_lock(mode_e) && (q_q == '0);

    lfsr_next #(
        .WIDTH(WIDTH),
        .TAPS (TAPS)
    ) u_next (
        .q_i     (q_q),
        .mode_i  (mode_e),
        .q_next_o(q_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q      <= SEED;
            anchor_q <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else if (L) begin
            q_q      <= r;
            anchor_q <= r;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else if (step_act) begin
            // Lock-up re-anchors at SEED, so it must never also report a wrap.
            if (is_lock) begin
                q_q      <= SEED;
                anchor_q <= SEED;
                cnt_q    <= '0;
                wrap_q   <= 1'b0;
                lockup_q <= 1'b1;
            end else if (q_d == anchor_q) begin
                q_q      <= q_d;
                period_q <= cnt_q + WIDTH'(1);
                cnt_q    <= '0;
                wrap_q   <= 1'b1;
                lockup_q <= 1'b0;
            end else begin
                q_q      <= q_d;
                cnt_q    <= (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);
                wrap_q   <= 1'b0;
                lockup_q <= 1'b0;
            end
        end else begin
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end
    end

    assign Q        = q_q;
    assign step_cnt = cnt_q;
    assign period   = period_q;
    assign wrap     = wrap_q;
    assign lockup   = lockup_q;

endmodule
